// File: rtl/pr_merger.sv
// pr_merger: round-robin merge of two packet-request streams into a small
// first-word-fall-through FIFO feeding the matching/dispatch stage.
module pr_merger #(
    parameter int unsigned PACKET_REQUEST_WIDTH = 99,
    parameter int unsigned FIFO_DEPTH           = 4,
    parameter int unsigned CNT_WIDTH            = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            A_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] A_DATA,
    output logic                            A_READY,
    input  logic                            B_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] B_DATA,
    output logic                            B_READY,
    output logic                            SEND_PR_VALID,
    output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
    input  logic                            SEND_PR_READY,
    output logic [CNT_WIDTH-1:0]            COUNT
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e                          last_grant;
    grant_e                          last_grant_nxt;
    logic [PACKET_REQUEST_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_WIDTH-1:0]            count;
    logic                            full;
    logic                            grant_a;
    logic                            grant_b;
    logic                            push_a;
    logic                            push_b;
    logic                            push;
    logic                            pop;
    logic [PACKET_REQUEST_WIDTH-1:0] push_data;

    // Round-robin grant, handshakes and next value of the grant history
    always_comb begin
        grant_a        = 1'b0;
        grant_b        = 1'b0;
        last_grant_nxt = last_grant;
        full           = (count == CNT_WIDTH'(FIFO_DEPTH));
        if (A_VALID && (!B_VALID || last_grant == GRANT_B)) begin
            grant_a = 1'b1;
        end else if (B_VALID) begin
            grant_b = 1'b1;
        end
        // No handshake may complete on the reset cycle
        A_READY   = !RST && !full && grant_a;
        B_READY   = !RST && !full && grant_b;
        push_a    = A_VALID && A_READY;
        push_b    = B_VALID && B_READY;
        push      = push_a || push_b;
        push_data = push_a ? A_DATA : B_DATA;
        pop       = !RST && SEND_PR_VALID && SEND_PR_READY;
        if (push_a) begin
            last_grant_nxt = GRANT_A;
        end else if (push_b) begin
            last_grant_nxt = GRANT_B;
        end
    end

    // Grant history register; B after reset so A wins the first tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign SEND_PR_VALID = (count != '0);
    assign SEND_PR_DATA  = mem[rd_ptr];
    assign COUNT         = count;

endmodule

// File: tb/tb_pr_merger.sv
// Directed bench for pr_merger: a vector table of per-cycle stimulus with
// hand-computed handshake/occupancy/head expectations, plus a stall sequence.
module tb_pr_merger;

    localparam int unsigned W = 99;

    logic         CLK;
    logic         RST;
    logic         A_VALID;
    logic [W-1:0] A_DATA;
    logic         A_READY;
    logic         B_VALID;
    logic [W-1:0] B_DATA;
    logic         B_READY;
    logic         SEND_PR_VALID;
    logic [W-1:0] SEND_PR_DATA;
    logic         SEND_PR_READY;
    logic [2:0]   COUNT;

    pr_merger #(
        .PACKET_REQUEST_WIDTH(W),
        .FIFO_DEPTH(4),
        .CNT_WIDTH(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .A_VALID(A_VALID),
        .A_DATA(A_DATA),
        .A_READY(A_READY),
        .B_VALID(B_VALID),
        .B_DATA(B_DATA),
        .B_READY(B_READY),
        .SEND_PR_VALID(SEND_PR_VALID),
        .SEND_PR_DATA(SEND_PR_DATA),
        .SEND_PR_READY(SEND_PR_READY),
        .COUNT(COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] at;
        logic       bv;
        logic [7:0] bt;
        logic       sr;
        logic       ear;
        logic       ebr;
        logic [2:0] ecnt;
        logic       evl;
        logic [7:0] et;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;
    int   step   = 0;

    // Distinct packet-request built from a small tag (all fields touched)
    function automatic logic [W-1:0] pr(input logic [7:0] t);
        return {t[2:0], 8'h00, t, 8'hC0, t, 24'h000000, t, t, 24'hABCDEF};
    endfunction

    function automatic vec_t v(input logic rst, input logic av, input logic [7:0] at,
                               input logic bv, input logic [7:0] bt, input logic sr,
                               input logic ear, input logic ebr, input logic [2:0] ecnt,
                               input logic evl, input logic [7:0] et);
        vec_t r;
        r.rst = rst; r.av = av; r.at = at; r.bv = bv; r.bt = bt; r.sr = sr;
        r.ear = ear; r.ebr = ebr; r.ecnt = ecnt; r.evl = evl; r.et = et;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; A_VALID = 1'b0; A_DATA = '0; B_VALID = 1'b0; B_DATA = '0;
        SEND_PR_READY = 1'b0;

        //              rst av at    bv bt    sr  ear ebr cnt val head
        // Reset cycle: READY low even with A valid
        vecs.push_back(v(1, 1, 8'd1,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        // Single A request, one-cycle latency, count 0->1->0
        vecs.push_back(v(0, 1, 8'd1,  0, 8'd0,  1,  1, 0, 3'd1, 1, 8'd1));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        // Reset, then continuous tie: A,B,A,B with pass-through
        vecs.push_back(v(1, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        vecs.push_back(v(0, 1, 8'd2,  1, 8'd3,  1,  1, 0, 3'd1, 1, 8'd2));
        vecs.push_back(v(0, 1, 8'd4,  1, 8'd3,  1,  0, 1, 3'd1, 1, 8'd3));
        vecs.push_back(v(0, 1, 8'd4,  1, 8'd5,  1,  1, 0, 3'd1, 1, 8'd4));
        vecs.push_back(v(0, 1, 8'd6,  1, 8'd5,  1,  0, 1, 3'd1, 1, 8'd5));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        // Stalled downstream: 4 accepted, 5th refused while full
        vecs.push_back(v(0, 1, 8'd10, 0, 8'd0,  0,  1, 0, 3'd1, 1, 8'd10));
        vecs.push_back(v(0, 1, 8'd11, 0, 8'd0,  0,  1, 0, 3'd2, 1, 8'd10));
        vecs.push_back(v(0, 1, 8'd12, 0, 8'd0,  0,  1, 0, 3'd3, 1, 8'd10));
        vecs.push_back(v(0, 1, 8'd13, 0, 8'd0,  0,  1, 0, 3'd4, 1, 8'd10));
        vecs.push_back(v(0, 1, 8'd14, 0, 8'd0,  0,  0, 0, 3'd4, 1, 8'd10));
        // Full with pop and A valid: no push, count 3; push next cycle
        vecs.push_back(v(0, 1, 8'd14, 0, 8'd0,  1,  0, 0, 3'd3, 1, 8'd11));
        vecs.push_back(v(0, 1, 8'd14, 0, 8'd0,  0,  1, 0, 3'd4, 1, 8'd11));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd3, 1, 8'd12));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd2, 1, 8'd13));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd1, 1, 8'd14));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        // Expander sequence 20..24 interleaved with B 30..32 (last grant is A)
        vecs.push_back(v(0, 1, 8'd20, 1, 8'd30, 1,  0, 1, 3'd1, 1, 8'd30));
        vecs.push_back(v(0, 1, 8'd20, 0, 8'd0,  1,  1, 0, 3'd1, 1, 8'd20));
        vecs.push_back(v(0, 0, 8'd0,  1, 8'd31, 1,  0, 1, 3'd1, 1, 8'd31));
        vecs.push_back(v(0, 1, 8'd21, 1, 8'd32, 1,  1, 0, 3'd1, 1, 8'd21));
        vecs.push_back(v(0, 0, 8'd0,  1, 8'd32, 1,  0, 1, 3'd1, 1, 8'd32));
        vecs.push_back(v(0, 1, 8'd22, 0, 8'd0,  1,  1, 0, 3'd1, 1, 8'd22));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        vecs.push_back(v(0, 1, 8'd23, 0, 8'd0,  1,  1, 0, 3'd1, 1, 8'd23));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        vecs.push_back(v(0, 1, 8'd24, 0, 8'd0,  1,  1, 0, 3'd1, 1, 8'd24));
        vecs.push_back(v(0, 0, 8'd0,  0, 8'd0,  1,  0, 0, 3'd0, 0, 8'd0));
        // Fill to 3, reset mid-operation, then first tie goes to A
        vecs.push_back(v(0, 1, 8'd40, 0, 8'd0,  0,  1, 0, 3'd1, 1, 8'd40));
        vecs.push_back(v(0, 1, 8'd41, 0, 8'd0,  0,  1, 0, 3'd2, 1, 8'd40));
        vecs.push_back(v(0, 1, 8'd42, 0, 8'd0,  0,  1, 0, 3'd3, 1, 8'd40));
        vecs.push_back(v(1, 1, 8'd43, 1, 8'd50, 1,  0, 0, 3'd0, 0, 8'd0));
        vecs.push_back(v(0, 1, 8'd43, 1, 8'd50, 0,  1, 0, 3'd1, 1, 8'd43));

        // Apply the table: READY sampled before the edge, state after it
        foreach (vecs[i]) begin
            step = i;
            @(negedge CLK);
            RST = vecs[i].rst;
            A_VALID = vecs[i].av; A_DATA = pr(vecs[i].at);
            B_VALID = vecs[i].bv; B_DATA = pr(vecs[i].bt);
            SEND_PR_READY = vecs[i].sr;
            #1;
            chk("a_ready", W'(A_READY), W'(vecs[i].ear));
            chk("b_ready", W'(B_READY), W'(vecs[i].ebr));
            @(posedge CLK);
            #1;
            chk("count", W'(COUNT), W'(vecs[i].ecnt));
            chk("send_valid", W'(SEND_PR_VALID), W'(vecs[i].evl));
            if (vecs[i].evl) begin
                chk("send_data", SEND_PR_DATA, pr(vecs[i].et));
            end
        end

        // Hand sequence: no same-cycle fall-through, head stable under stall
        step = 1000;
        @(negedge CLK);
        RST = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0; SEND_PR_READY = 1'b0;
        @(negedge CLK);
        RST = 1'b0; A_VALID = 1'b1; A_DATA = pr(8'd60);
        #1;
        chk("seq_a_ready", W'(A_READY), W'(1));
        chk("seq_valid_same_cycle", W'(SEND_PR_VALID), W'(0));
        @(negedge CLK);
        chk("seq_head_first", SEND_PR_DATA, pr(8'd60));
        A_VALID = 1'b0; B_VALID = 1'b1; B_DATA = pr(8'd61);
        @(negedge CLK);
        B_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step = 1001 + k;
            chk("seq_head_stable", SEND_PR_DATA, pr(8'd60));
            chk("seq_count_stall", W'(COUNT), W'(2));
            @(negedge CLK);
        end
        SEND_PR_READY = 1'b1;
        @(negedge CLK);
        SEND_PR_READY = 1'b0;
        step = 1010;
        chk("seq_head_after_pop", SEND_PR_DATA, pr(8'd61));
        chk("seq_count_after_pop", W'(COUNT), W'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
